// File: rtl/ntt_seq_if.sv
// Host/memory-side bus of the Kyber NTT sequencer: start/mode in, status,
// read/twiddle addresses and aligned write-back strobes out.
interface ntt_seq_if;
    logic       start;
    logic       ct_in;
    logic       busy;
    logic       done;
    logic       bf_ct;
    logic [2:0] layer;
    logic       rd_en;
    logic [7:0] rd_addr_a;
    logic [7:0] rd_addr_b;
    logic [6:0] tw_addr;
    logic       wr_en;
    logic [7:0] wr_addr_a;
    logic [7:0] wr_addr_b;

    modport master (
        output start, ct_in,
        input  busy, done, bf_ct, layer, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        input  start, ct_in,
        output busy, done, bf_ct, layer, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_seq_ctrl.sv
// Kyber (q=3329, n=256) in-place NTT/invNTT sequencer: 7 layers x 128 butterflies,
// with a drain gap per layer and write-back addresses delayed to match the butterfly.
module ntt_seq_ctrl #(
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned BF_LAT_CT = 4,
    parameter int unsigned BF_LAT_GS = 4
) (
    input logic      clk,
    input logic      rst,
    ntt_seq_if.slave seq_if
);
    localparam int unsigned D_CT   = MEM_LAT + BF_LAT_CT;
    localparam int unsigned D_GS   = MEM_LAT + BF_LAT_GS;
    localparam int unsigned D_MAX  = (D_CT > D_GS) ? D_CT : D_GS;
    localparam int unsigned CNT_W  = $clog2(D_MAX + 1);
    localparam int unsigned J_W    = 7;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned TW_W   = 7;
    localparam int unsigned LYR_W  = 3;
    localparam int unsigned INS_CT = D_MAX - D_CT;
    localparam int unsigned INS_GS = D_MAX - D_GS;

    localparam logic [J_W-1:0]   J_LAST     = J_W'(127);
    localparam logic [LYR_W-1:0] LAYER_LAST = LYR_W'(6);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
    } wb_t;

    localparam wb_t WB_IDLE = '0;

    state_e            state_q, state_d;
    logic              ct_q, ct_d;
    logic [LYR_W-1:0]  layer_q, layer_d;
    logic [J_W-1:0]    j_q, j_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_a_q, rd_a_d;
    logic [ADDR_W-1:0] rd_b_q, rd_b_d;
    logic [TW_W-1:0]   tw_q, tw_d;

    logic [LYR_W-1:0]  s_c;
    logic [ADDR_W-1:0] len_c, g_c, jx_c, a_c, b_c;
    logic [TW_W-1:0]   tw_c;

    // Butterfly j of the current layer: span len = 2^s, group g = j >> s
    always_comb begin
        s_c   = ct_q ? LYR_W'(3'd7 - layer_q) : LYR_W'(layer_q + 3'd1);
        jx_c  = {1'b0, j_q};
        len_c = 8'd1 << s_c;
        g_c   = jx_c >> s_c;
        a_c   = ((g_c << s_c) << 1) | (jx_c & (len_c - 8'd1));
        b_c   = a_c + len_c;
        tw_c  = ct_q ? TW_W'((8'd1 << layer_q) + g_c)
                     : TW_W'((8'd128 >> layer_q) - 8'd1 - g_c);
    end

    always_comb begin
        state_d = state_q;
        ct_d    = ct_q;
        layer_d = layer_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_en_d = 1'b0;
        rd_a_d  = rd_a_q;
        rd_b_d  = rd_b_q;
        tw_d    = tw_q;
        unique case (state_q)
            IDLE: begin
                if (seq_if.start) begin
                    state_d = RUN;
                    ct_d    = seq_if.ct_in;
                    layer_d = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                rd_en_d = 1'b1;
                rd_a_d  = a_c;
                rd_b_d  = b_c;
                tw_d    = tw_c;
                if (j_q == J_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = ct_q ? CNT_W'(D_CT - 1) : CNT_W'(D_GS - 1);
                end else begin
                    j_d = j_q + J_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (layer_q == LAYER_LAST) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                    layer_d = layer_q + LYR_W'(1);
                    j_d     = '0;
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ct_q    <= 1'b0;
            layer_q <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            ct_q    <= ct_d;
            layer_q <= layer_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            tw_q    <= tw_d;
        end
    end

    // Write-back delay line: entries are injected D_MAX-D stages in so the tail is always the output
    wb_t         line_q [D_MAX];
    wb_t         rd_wb_c;
    int unsigned ins_idx_c;

    assign rd_wb_c   = {rd_en_q, rd_a_q, rd_b_q};
    assign ins_idx_c = ct_q ? INS_CT : INS_GS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < D_MAX; k++) begin
                line_q[k] <= WB_IDLE;
            end
        end else begin
            line_q[0] <= (ins_idx_c == 0) ? rd_wb_c : WB_IDLE;
            for (int unsigned k = 1; k < D_MAX; k++) begin
                line_q[k] <= (k == ins_idx_c) ? rd_wb_c : line_q[k-1];
            end
        end
    end

    assign seq_if.busy      = busy_q;
    assign seq_if.done      = done_q;
    assign seq_if.bf_ct     = ct_q;
    assign seq_if.layer     = layer_q;
    assign seq_if.rd_en     = rd_en_q;
    assign seq_if.rd_addr_a = rd_a_q;
    assign seq_if.rd_addr_b = rd_b_q;
    assign seq_if.tw_addr   = tw_q;
    assign seq_if.wr_en     = line_q[D_MAX-1].en;
    assign seq_if.wr_addr_a = line_q[D_MAX-1].a;
    assign seq_if.wr_addr_b = line_q[D_MAX-1].b;
endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// Bench for ntt_seq_ctrl: drives full NTT/invNTT passes over a RAM + butterfly model
// and compares addresses, timing and the transformed polynomial against Kyber loops.
module tb_ntt_seq_ctrl;
    localparam int MEM_LAT   = 1;
    localparam int BF_LAT_CT = 4;
    localparam int BF_LAT_GS = 3;
    localparam int Q         = 3329;
    localparam int INV2      = 1665;
    localparam int INV128    = 3303;
    localparam int N_RD      = 7 * 128;

    typedef struct { int a; int b; int k; } rd_t;
    typedef struct { int e; int o; int a; int b; int c; } pend_t;

    logic clk = 1'b0;
    logic rst;

    ntt_seq_if seq ();

    ntt_seq_ctrl #(
        .MEM_LAT  (MEM_LAT),
        .BF_LAT_CT(BF_LAT_CT),
        .BF_LAT_GS(BF_LAT_GS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .seq_if(seq)
    );

    rd_t   exp_q[$];
    pend_t pend_q[$];
    int    ram [256];
    int    gold [256];
    int    zeta_tab [128];
    int    cyc = 0;
    int    n_assert = 0;
    int    n_fail = 0;
    int    n_rd, last_rd_cyc, done_cyc, start_cyc, d_exp;
    bit    mode_ct;
    bit    mon_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int modq(input int x);
        int r;
        r = x % Q;
        return (r < 0) ? r + Q : r;
    endfunction

    // Reference Kyber loops (plain arithmetic, inverse scaled by 1/128 at the end)
    task automatic golden(input bit ct);
        int k, t;
        gold = ram;
        if (ct) begin
            k = 1;
            for (int len = 128; len >= 2; len = len / 2)
                for (int st = 0; st < 256; st += 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        t = modq(zeta_tab[k] * gold[j+len]);
                        gold[j+len] = modq(gold[j] - t);
                        gold[j]     = modq(gold[j] + t);
                    end
                    k++;
                end
        end else begin
            k = 127;
            for (int len = 2; len <= 128; len = len * 2)
                for (int st = 0; st < 256; st += 2 * len) begin
                    for (int j = st; j < st + len; j++) begin
                        t = gold[j];
                        gold[j]     = modq(t + gold[j+len]);
                        gold[j+len] = modq(zeta_tab[k] * modq(gold[j+len] - t));
                    end
                    k--;
                end
            for (int i = 0; i < 256; i++) gold[i] = modq(gold[i] * INV128);
        end
    endtask

    // Expected read order: same loop nest, recording (j, j+len, zeta index)
    task automatic build_exp(input bit ct);
        int k;
        exp_q.delete();
        k = ct ? 1 : 127;
        for (int l = 0; l < 7; l++) begin
            int len;
            len = ct ? (128 >> l) : (2 << l);
            for (int st = 0; st < 256; st += 2 * len) begin
                for (int j = st; j < st + len; j++) exp_q.push_back('{j, j + len, k});
                k = ct ? k + 1 : k - 1;
            end
        end
    endtask

    // RAM + butterfly model driven by the DUT strobes; reads use pre-write RAM contents
    int    m_av, m_bv, m_wv, m_t, m_e, m_o;
    rd_t   m_x;
    pend_t m_p;
    always @(negedge clk) begin
        if (mon_on) begin
            if (seq.rd_en === 1'b1) begin
                if (last_rd_cyc >= 0 && cyc - last_rd_cyc > 1) begin
                    chk("layer_gap", cyc - last_rd_cyc - 1, d_exp);
                    chk("prev_layer_written", pend_q.size(), 0);
                end
                last_rd_cyc = cyc;
                chk("bf_ct_stable", seq.bf_ct, mode_ct);
                chk("rd_in_budget", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    m_x = exp_q.pop_front();
                    chk("rd_addr_a", seq.rd_addr_a, m_x.a);
                    chk("rd_addr_b", seq.rd_addr_b, m_x.b);
                    chk("tw_addr", seq.tw_addr, m_x.k);
                end
                m_av = ram[seq.rd_addr_a];
                m_bv = ram[seq.rd_addr_b];
                m_wv = zeta_tab[seq.tw_addr];
                if (mode_ct) begin
                    m_t = modq(m_wv * m_bv);
                    m_e = modq(m_av + m_t);
                    m_o = modq(m_av - m_t);
                end else begin
                    m_e = modq((m_av + m_bv) * INV2);
                    m_o = modq(modq(modq(m_bv - m_av) * m_wv) * INV2);
                end
                pend_q.push_back('{m_e, m_o, int'(seq.rd_addr_a), int'(seq.rd_addr_b), cyc});
                n_rd++;
            end
            if (seq.wr_en === 1'b1) begin
                chk("wr_has_pending", pend_q.size() > 0, 1);
                if (pend_q.size() > 0) begin
                    m_p = pend_q.pop_front();
                    chk("wr_latency", cyc - m_p.c, d_exp);
                    chk("wr_addr_a", seq.wr_addr_a, m_p.a);
                    chk("wr_addr_b", seq.wr_addr_b, m_p.b);
                    ram[seq.wr_addr_a] = m_p.e;
                    ram[seq.wr_addr_b] = m_p.o;
                end
            end
            if (seq.done === 1'b1) begin
                chk("single_done", done_cyc < 0, 1);
                chk("last_wr_with_done", seq.wr_en, 1);
                done_cyc = cyc;
            end
        end
    end

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_busy"}, seq.busy, 0);
        chk({pfx, "_done"}, seq.done, 0);
        chk({pfx, "_bf_ct"}, seq.bf_ct, 0);
        chk({pfx, "_layer"}, seq.layer, 0);
        chk({pfx, "_rd_en"}, seq.rd_en, 0);
        chk({pfx, "_rd_addr_a"}, seq.rd_addr_a, 0);
        chk({pfx, "_rd_addr_b"}, seq.rd_addr_b, 0);
        chk({pfx, "_tw_addr"}, seq.tw_addr, 0);
        chk({pfx, "_wr_en"}, seq.wr_en, 0);
        chk({pfx, "_wr_addr_a"}, seq.wr_addr_a, 0);
        chk({pfx, "_wr_addr_b"}, seq.wr_addr_b, 0);
    endtask

    task automatic begin_pass(input bit ct);
        for (int i = 0; i < 256; i++) ram[i] = int'($urandom_range(0, Q - 1));
        golden(ct);
        build_exp(ct);
        pend_q.delete();
        n_rd        = 0;
        last_rd_cyc = -1;
        done_cyc    = -1;
        mode_ct     = ct;
        d_exp       = MEM_LAT + (ct ? BF_LAT_CT : BF_LAT_GS);
        mon_on      = 1'b1;
        @(negedge clk);
        chk("idle_before_start", seq.busy, 0);
        seq.start = 1'b1;
        seq.ct_in = ct;
        start_cyc = cyc;
        @(negedge clk);
        seq.start = 1'b0;
        seq.ct_in = ~ct;
        #1;
        chk("busy_rise", seq.busy, 1);
        chk("mode_captured", seq.bf_ct, ct);
    endtask

    task automatic finish_pass(input bit ct);
        int mism;
        for (int i = 0; i < 4000 && done_cyc < 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_seen", done_cyc >= 0, 1);
        chk(ct ? "cycles_ct" : "cycles_gs", done_cyc - start_cyc + 1, 1 + 7 * (128 + d_exp) + 1);
        @(negedge clk);
        #1;
        chk("busy_drop", seq.busy, 0);
        chk("done_one_cycle", seq.done, 0);
        chk("rd_count", n_rd, N_RD);
        chk("writes_drained", pend_q.size(), 0);
        mism = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != gold[i]) mism++;
        chk(ct ? "ntt_result" : "invntt_result", mism, 0);
        mon_on = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 128; k++) begin
            int e, z;
            e = 0;
            for (int b = 0; b < 7; b++) e |= ((k >> b) & 1) << (6 - b);
            z = 1;
            for (int i = 0; i < e; i++) z = modq(z * 17);
            zeta_tab[k] = z;
        end

        rst       = 1'b1;
        seq.start = 1'b0;
        seq.ct_in = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");

        // start while in reset must be dropped
        seq.start = 1'b1;
        seq.ct_in = 1'b1;
        @(negedge clk);
        seq.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_wins_busy", seq.busy, 0);
        chk("rst_wins_bf_ct", seq.bf_ct, 0);

        // forward pass with an ignored, mode-flipped start at layer 3
        begin_pass(1'b1);
        for (int i = 0; i < 2000 && seq.layer !== 3'd3; i++) @(negedge clk);
        chk("hazard_layer3_reached", seq.layer, 3);
        seq.start = 1'b1;
        seq.ct_in = 1'b0;
        @(negedge clk);
        seq.start = 1'b0;
        #1;
        chk("hazard_mode_kept", seq.bf_ct, 1);
        finish_pass(1'b1);

        // inverse pass on a fresh polynomial
        begin_pass(1'b0);
        finish_pass(1'b0);

        // reset at layer 2, j = 40
        begin_pass(1'b1);
        for (int i = 0; i < 2000 && n_rd < 2 * 128 + 41; i++) begin
            @(negedge clk);
            #1;
        end
        chk("mid_rst_point", n_rd, 2 * 128 + 41);
        mon_on = 1'b0;
        rst    = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("post_rst_busy", seq.busy, 0);
        chk("post_rst_wr_en", seq.wr_en, 0);

        // full pass after the abort
        begin_pass(1'b1);
        finish_pass(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ntt_seq_ctrl.md
Name: ntt_seq_ctrl

Overview:
- Sequencer that drives the Kyber butterfly unit (q = 3329, n = 256) for a complete in-place NTT (CT, forward) or inverse NTT (GS).
- Sits directly upstream of the butterfly. It issues coefficient-RAM read addresses and twiddle-ROM addresses, and drives the butterfly mode bit.
- Produces write-back addresses and a write enable, delayed to line up with the butterfly E/O outputs.
- Inserts a drain gap between layers so that no read of layer L+1 occurs before every write of layer L has landed.

Parameters:
- MEM_LAT, 1, coefficient-RAM and twiddle-ROM read latency in cycles (rd_en to data valid at butterfly inputs).
- BF_LAT_CT, 4, butterfly latency in cycles, A/B/W in to E/O out, CT mode.
- BF_LAT_GS, 4, butterfly latency in cycles, A/B/W in to E/O out, GS mode.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle start pulse; sampled only in IDLE
- ct_in  in  1  mode, captured at start: 1 = forward NTT (CT), 0 = inverse NTT (GS)
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the final write is issued
- bf_ct  out  1  registered copy of the captured mode; drives butterfly CT; stable while busy
- layer  out  3  current layer, 0..6
- rd_en  out  1  read strobe for both coefficient ports and the twiddle ROM
- rd_addr_a  out  8  coefficient address of the even operand (A)
- rd_addr_b  out  8  coefficient address of the odd operand (B)
- tw_addr  out  7  twiddle-ROM index
- wr_en  out  1  write strobe, aligned with valid butterfly E/O
- wr_addr_a  out  8  write address for E
- wr_addr_b  out  8  write address for O

Behaviour:
- Reset values: every output is 0. FSM state is IDLE, and all counters and delay lines are cleared.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: on start, capture ct_in, set layer = 0 and j = 0, go to RUN. busy rises the next cycle.
  - RUN: assert rd_en every cycle and issue butterfly j (7-bit counter, 0..127). When j = 127, go to DRAIN with drain counter D = MEM_LAT + BF_LAT (the CT or GS value, per captured mode).
  - DRAIN: rd_en = 0. Count down D.
    - At 0 with layer < 6: increment layer, set j = 0, return to RUN.
    - At 0 with layer = 6: go to FIN.
  - FIN: pulse done for one cycle, drop busy, go to IDLE.
- Address generation, registered, presented in the same cycle as rd_en. Definitions:
  - s = log2(len), len = 2^s, g = j >> s.
  - a = ((j >> s) << (s+1)) | (j & (len-1)), b = a + len.
- Forward mode (ct = 1):
  - s = 7 - layer, so len = 128 down to 2.
  - tw_addr = (1 << layer) + g.
- Inverse mode (ct = 0):
  - s = layer + 1, so len = 2 up to 128.
  - tw_addr = (128 >> layer) - 1 - g.
- Write-back:
  - {rd_en, rd_addr_a, rd_addr_b} passes through a delay line of MEM_LAT + BF_LAT(mode) cycles and emerges as {wr_en, wr_addr_a, wr_addr_b}.
  - The delay is selected by the captured mode and is constant during a run.
- Throughput: one butterfly per cycle inside a layer. Total cycles from start to done = 1 + 7*(128 + MEM_LAT + BF_LAT) + 1.
- The last wr_en of layer 6 is asserted in the same cycle as done.
- Final multiplication by n^-1 for the inverse NTT is done by the butterfly div2 path. The sequencer does no arithmetic on data.
- Boundary conditions:
  - start while busy: ignored; ct_in is not re-sampled.
  - start and rst together: rst wins.
  - rst mid-run: immediate return to IDLE with all outputs 0. In-flight writes are discarded (wr_en forced 0).
  - j wraps 127 -> 0 only via DRAIN, never directly inside RUN.
  - Addresses never exceed 255 and tw_addr never reaches 0 in either mode.
- Outputs hold their last value when rd_en / wr_en = 0, except the strobes themselves.

Test Plan:
- Forward run, MEM_LAT = 1, BF_LAT_CT = 4:
  - start with ct_in = 1; busy rises next cycle.
  - Layer 0, j = 0 -> a = 0, b = 128, tw = 1. j = 127 -> a = 127, b = 255, tw = 1.
  - Layer 6: j = 0 -> (0, 2, tw 64); j = 2 -> (4, 6, tw 65); j = 127 -> (253, 255, tw 127).
  - done exactly 1 + 7*133 + 1 = 933 cycles after start.
- Inverse run, ct_in = 0:
  - Layer 0: j = 0 -> (0, 2, tw 127); j = 1 -> (1, 3, tw 127); j = 2 -> (4, 6, tw 126).
  - Layer 6: j = 5 -> (5, 133, tw 1).
  - bf_ct = 0 throughout.
- Write alignment: every wr_en edge lags the matching rd_en edge by exactly MEM_LAT + BF_LAT, and wr_addr_a/b equal the delayed rd_addr_a/b. A scoreboard with a butterfly reference model plus RAM must match a golden Kyber NTT/invNTT of a random polynomial.
- Layer gap:
  - rd_en is low for exactly MEM_LAT + BF_LAT cycles between layers.
  - No rd_addr of layer L+1 is issued before the last wr_en of layer L.
- Control hazards:
  - A start pulse at layer 3 with ct_in flipped is ignored; mode and cycle count are unchanged.
  - rst asserted at layer 2, j = 40 -> all outputs 0 the same cycle.
  - A fresh start afterwards runs a full 933-cycle pass correctly.
